uartrx_fifo: RTL and testbench
==============================

# uartrx_fifo

Receive buffer between the `uartrx` byte receiver and the I/O port logic serving the UART-in address. It acknowledges every byte `uartrx` reports, pushes it into a circular FIFO, and presents the oldest byte as a zero-extended 32-bit word (or -1 when empty) for the CPU-facing read path. This prevents dropped characters when the CPU polls slower than bytes arrive.

## Interface
- `DepthBitWidth`, default 4: FIFO depth is 2^DepthBitWidth bytes.
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: reset; synchronous, active-low.
- `uartrx_go` output, 1 bit: to `uartrx.go`. 1 enables receiving; a one-cycle 0 pulse acknowledges a received byte.
- `uartrx_data` input, 8 bits: byte from `uartrx`. Valid when `uartrx_data_ready` is 1.
- `uartrx_data_ready` input, 1 bit: `uartrx` has a complete byte.
- `rd_en` input, 1 bit: pop strobe. Asserted by the I/O logic for each cycle in which the UART-in address is read.
- `rd_data` output, 32 bits: head byte zero-extended as {24'h0, byte}, or 32'hffff_ffff when empty.
- `empty` output, 1 bit: FIFO holds 0 entries.
- `full` output, 1 bit: FIFO holds 2^DepthBitWidth entries.
- `count` output, DepthBitWidth+1 bits: number of stored entries.
- `overrun` output, 1 bit: sticky flag; a byte was dropped because the FIFO was full.
- `overrun_clear` input, 1 bit: clears `overrun`.

## Operation
- Storage: 2^DepthBitWidth × 8-bit register array.
- Pointers: write pointer `wr_ptr` and read pointer `rd_ptr`, each DepthBitWidth bits, wrapping modulo depth.
- Count register: `count`, DepthBitWidth+1 bits, so the full depth is representable.
- Receive handshake (two states, RECV and ACK):
  - RECV, `uartrx_go`=1: when `uartrx_data_ready`=1, capture the byte (push) and move to ACK.
  - ACK, `uartrx_go`=0 for exactly one cycle, then return to RECV.
  - A byte is captured at most once per handshake.
- Push when not full: write to `mem[wr_ptr]`, increment `wr_ptr`, increment `count`.
- Push when full, with no pop that cycle: drop the byte, set `overrun`=1. The handshake still completes normally (ACK pulse is issued).
- Pop when `rd_en`=1 and not empty: increment `rd_ptr`, decrement `count`. Pop when empty is ignored.
- Simultaneous push and pop:
  - Non-empty, non-full: both take effect; `count` is unchanged.
  - Full: the pop frees a slot, so the push is accepted and `overrun` is not set.
  - Empty: the pop is ignored and the push is accepted; `count` becomes 1.
- `rd_data`, `empty` and `full` are combinational from registered state (first-word fall-through).
- `rd_en` held high for N cycles pops up to N entries. This matches the per-cycle read strobe of the I/O path.
- `overrun_clear`=1 clears `overrun`. If a drop happens in the same cycle, set wins.

## Timing
- Reset values: `uartrx_go`=1, state RECV, `wr_ptr`=`rd_ptr`=0, `count`=0, `empty`=1, `full`=0, `overrun`=0, `rd_data`=32'hffff_ffff. Memory contents are not reset.
- A byte captured at rising edge N appears on `rd_data`/`count` after edge N; it is poppable in cycle N+1.
- `uartrx_go`=0 during the cycle after edge N, and is 1 again after edge N+1.
- Minimum spacing between accepted bytes: 2 cycles.
- A pop strobed in cycle M advances `rd_data` to the next entry (or -1) after edge M.
- Reset asserted mid-handshake or mid-stream: all state returns to reset values at that edge. Buffered bytes are discarded.

## Configuration
- Macro: `UARTRX_FIFO_OVERRUN_EN`.
- Defined: `overrun` is implemented as specified above.
- Undefined: `overrun` is tied to 0, `overrun_clear` is ignored, and full-FIFO drops happen silently. All other behaviour is identical.

## Test plan
- Reset, then idle: `rd_data`=32'hffff_ffff, `empty`=1, `count`=0, `uartrx_go`=1. A `rd_en` pulse leaves all outputs unchanged.
- Push 8'h41, 8'h42 via the `uartrx` handshake, then pop twice: `rd_data` reads 32'h0000_0041, then 32'h0000_0042, then 32'hffff_ffff. `uartrx_go` shows a 1-cycle low after each capture.
- DepthBitWidth=2, push 5 bytes 8'h01..8'h05 with no pops: `full`=1, `count`=4, `overrun`=1 (macro defined). Pops return 01, 02, 03, 04; 8'h05 is lost.
- Full FIFO, push 8'h55 in the same cycle as `rd_en`: `count` stays 4, `overrun` stays 0, and 8'h55 is the last entry popped.
- Empty FIFO, push 8'h7a with `rd_en`=1 in the capture cycle: `count`=1 and `rd_data`=32'h0000_007a in the next cycle.
- 3 bytes buffered, assert `rst_n`=0 for one cycle during an ACK: `count`=0, `rd_data`=32'hffff_ffff, `uartrx_go`=1 after the reset edge.

Source files
------------

// File: rtl/uartrx_fifo.sv
// uartrx_fifo: receive buffer between the uartrx byte receiver and the
// CPU-facing UART-in read port. Acknowledges each received byte, stores it in
// a circular FIFO and presents the oldest byte zero-extended (or all-ones when
// empty) with first-word fall-through.
// Optional feature macro: UARTRX_FIFO_OVERRUN_EN (sticky overrun flag).
module uartrx_fifo #(
   parameter int unsigned DepthBitWidth = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     uartrx_go,
   input  logic [7:0]               uartrx_data,
   input  logic                     uartrx_data_ready,
   input  logic                     rd_en,
   output logic [31:0]              rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [DepthBitWidth:0]   count,
   output logic                     overrun,
   input  logic                     overrun_clear
);

   localparam int unsigned Depth = 2 ** DepthBitWidth;
   localparam logic [DepthBitWidth:0]   FullCount = (DepthBitWidth + 1)'(Depth);
   localparam logic [DepthBitWidth:0]   CntOne    = 1;
   localparam logic [DepthBitWidth-1:0] PtrOne    = 1;

   typedef enum logic {StRecv, StAck} state_e;

   state_e                   state_q, state_d;
   logic [7:0]               mem_q [Depth];
   logic [DepthBitWidth-1:0] wr_ptr_q, rd_ptr_q;
   logic [DepthBitWidth:0]   count_q, count_d;

   logic push, pop, accept, drop;

   // Flags and fall-through read data, all from registered state.
   always_comb begin
      empty   = (count_q == '0);
      full    = (count_q == FullCount);
      count   = count_q;
      rd_data = empty ? 32'hffff_ffff : {24'h0, mem_q[rd_ptr_q]};
   end

   // Push/pop decode; a pop on a full FIFO frees the slot for a same-cycle push.
   always_comb begin
      push   = (state_q == StRecv) && uartrx_data_ready;
      pop    = rd_en && !empty;
      accept = push && (!full || pop);
      drop   = push && full && !pop;
   end

   // Handshake next state and the go strobe back to uartrx.
   always_comb begin
      state_d   = state_q;
      uartrx_go = (state_q == StRecv);
      unique case (state_q)
         StRecv:  if (push) state_d = StAck;
         StAck:   state_d = StRecv;
         default: state_d = StRecv;
      endcase
   end

   // Occupancy next value.
   always_comb begin
      count_d = count_q;
      case ({accept, pop})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   // Handshake state, pointers and count; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StRecv;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (accept) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (pop)    rd_ptr_q <= rd_ptr_q + PtrOne;
      end
   end

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_ptr_q] <= uartrx_data;
   end

`ifdef UARTRX_FIFO_OVERRUN_EN
   logic overrun_q;

   // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (drop) begin
         overrun_q <= 1'b1;
      end else if (overrun_clear) begin
         overrun_q <= 1'b0;
      end
   end

   assign overrun = overrun_q;
`else
   // Feature disabled: drops are silent and the clear input has no effect.
   logic unused_overrun;
   assign unused_overrun = overrun_clear ^ drop;
   assign overrun        = 1'b0;
`endif

endmodule

// File: tb/tb_uartrx_fifo.sv
// tb_uartrx_fifo: scoreboard bench for uartrx_fifo with a depth-4 FIFO.
// Stimulus pushes expected bytes into a queue once they are known to be
// accepted; a monitor compares rd_data against the queue on every read strobe.
module tb_uartrx_fifo;

`ifdef UARTRX_FIFO_OVERRUN_EN
   localparam logic OvrEn = 1'b1;
`else
   localparam logic OvrEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        uartrx_go;
   logic [7:0]  uartrx_data;
   logic        uartrx_data_ready;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        empty;
   logic        full;
   logic [2:0]  count;
   logic        overrun;
   logic        overrun_clear;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q [$];

   uartrx_fifo #(.DepthBitWidth(2)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .uartrx_go         (uartrx_go),
      .uartrx_data       (uartrx_data),
      .uartrx_data_ready (uartrx_data_ready),
      .rd_en             (rd_en),
      .rd_data           (rd_data),
      .empty             (empty),
      .full              (full),
      .count             (count),
      .overrun           (overrun),
      .overrun_clear     (overrun_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every read strobe is compared against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && rd_en) begin
         if (exp_q.size() > 0) chk("rd_data", rd_data, {24'h0, exp_q.pop_front()});
         else                  chk("rd_data_empty", rd_data, 32'hffff_ffff);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One uartrx handshake; optional same-cycle pop and overrun clear.
   task automatic send_byte(input logic [7:0] b, input logic accepted,
                            input logic with_pop, input logic with_clr);
      int waited = 0;
      while (uartrx_go !== 1'b1 && waited < 20) begin
         tick();
         waited++;
      end
      if (waited >= 20) chk("go_wait_timeout", 32'd0, 32'd1);
      uartrx_data       = b;
      uartrx_data_ready = 1'b1;
      rd_en             = with_pop;
      overrun_clear     = with_clr;
      tick();
      uartrx_data_ready = 1'b0;
      rd_en             = 1'b0;
      overrun_clear     = 1'b0;
      if (accepted) exp_q.push_back(b);
      chk("go_ack_low", {31'h0, uartrx_go}, 32'd0);
      tick();
      chk("go_back_high", {31'h0, uartrx_go}, 32'd1);
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      rst_n             = 1'b0;
      uartrx_data       = 8'h00;
      uartrx_data_ready = 1'b0;
      rd_en             = 1'b0;
      overrun_clear     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state.
      chk("rst_rd_data", rd_data, 32'hffff_ffff);
      chk("rst_empty", {31'h0, empty}, 32'd1);
      chk("rst_full", {31'h0, full}, 32'd0);
      chk("rst_count", {29'h0, count}, 32'd0);
      chk("rst_go", {31'h0, uartrx_go}, 32'd1);
      chk("rst_overrun", {31'h0, overrun}, 32'd0);

      // Pop on empty is ignored.
      pop_one();
      chk("empty_pop_count", {29'h0, count}, 32'd0);
      chk("empty_pop_empty", {31'h0, empty}, 32'd1);

      // Two bytes through the handshake, then drain.
      send_byte(8'h41, 1'b1, 1'b0, 1'b0);
      chk("after_41_count", {29'h0, count}, 32'd1);
      send_byte(8'h42, 1'b1, 1'b0, 1'b0);
      chk("after_42_count", {29'h0, count}, 32'd2);
      chk("head_41", rd_data, 32'h0000_0041);
      pop_one();
      pop_one();
      pop_one();
      chk("drained_empty", {31'h0, empty}, 32'd1);

      // Overfill: fifth byte dropped, clear in the drop cycle loses to set.
      send_byte(8'h01, 1'b1, 1'b0, 1'b0);
      send_byte(8'h02, 1'b1, 1'b0, 1'b0);
      send_byte(8'h03, 1'b1, 1'b0, 1'b0);
      send_byte(8'h04, 1'b1, 1'b0, 1'b0);
      chk("fill_overrun_clear", {31'h0, overrun}, 32'd0);
      send_byte(8'h05, 1'b0, 1'b0, 1'b1);
      chk("over_full", {31'h0, full}, 32'd1);
      chk("over_count", {29'h0, count}, 32'd4);
      chk("over_overrun", {31'h0, overrun}, {31'h0, OvrEn});
      overrun_clear = 1'b1;
      tick();
      overrun_clear = 1'b0;
      chk("overrun_cleared", {31'h0, overrun}, 32'd0);
      for (int i = 0; i < 5; i++) pop_one();
      chk("over_drained", {29'h0, count}, 32'd0);

      // Full FIFO with push and pop in the same cycle.
      send_byte(8'h11, 1'b1, 1'b0, 1'b0);
      send_byte(8'h22, 1'b1, 1'b0, 1'b0);
      send_byte(8'h33, 1'b1, 1'b0, 1'b0);
      send_byte(8'h44, 1'b1, 1'b0, 1'b0);
      send_byte(8'h55, 1'b1, 1'b1, 1'b0);
      chk("fullpp_count", {29'h0, count}, 32'd4);
      chk("fullpp_overrun", {31'h0, overrun}, 32'd0);
      for (int i = 0; i < 4; i++) pop_one();
      chk("fullpp_empty", {31'h0, empty}, 32'd1);

      // Empty FIFO with push and pop in the same cycle.
      send_byte(8'h7a, 1'b1, 1'b1, 1'b0);
      chk("emptypp_count", {29'h0, count}, 32'd1);
      chk("emptypp_rd_data", rd_data, 32'h0000_007a);
      pop_one();

      // Reset during an ACK with three bytes buffered.
      send_byte(8'ha1, 1'b1, 1'b0, 1'b0);
      send_byte(8'ha2, 1'b1, 1'b0, 1'b0);
      send_byte(8'ha3, 1'b1, 1'b0, 1'b0);
      uartrx_data       = 8'hb4;
      uartrx_data_ready = 1'b1;
      tick();
      uartrx_data_ready = 1'b0;
      chk("ack_before_reset", {31'h0, uartrx_go}, 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      chk("rstack_count", {29'h0, count}, 32'd0);
      chk("rstack_rd_data", rd_data, 32'hffff_ffff);
      chk("rstack_go", {31'h0, uartrx_go}, 32'd1);

      // Normal operation after the mid-stream reset.
      send_byte(8'hc3, 1'b1, 1'b0, 1'b0);
      chk("post_rst_head", rd_data, 32'h0000_00c3);
      pop_one();
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
